// File: rtl/icache_param.sv
// Direct-mapped instruction cache with multi-word blocks, a block-fill FSM,
// whole-cache flush and saturating hit/miss counters.
module icache_param #(
    parameter int SETS  = 16,
    parameter int WORDS = 2,
    parameter int CNTW  = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            imemREN,
    input  logic [31:0]     imemaddr,
    output logic            ihit,
    output logic [31:0]     imemload,
    input  logic            flush,
    output logic            iREN,
    output logic [31:0]     iaddr,
    input  logic            iwait,
    input  logic [31:0]     iload,
    output logic [CNTW-1:0] hit_count,
    output logic [CNTW-1:0] miss_count
);

    localparam int OFFB = $clog2(WORDS);
    localparam int IDXB = $clog2(SETS);
    localparam int TAGW = 30 - OFFB - IDXB;
    localparam int KW   = (OFFB > 0) ? OFFB : 1;
    localparam int DW   = OFFB + IDXB;
    localparam logic [KW-1:0] LAST_K = KW'(WORDS - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

    logic [0:0]      state;
    logic [SETS-1:0] valid;
    logic [TAGW-1:0] tags [SETS];
    logic [31:0]     data [SETS*WORDS];
    logic [TAGW-1:0] fill_tag;
    logic [IDXB-1:0] fill_idx;
    logic [KW-1:0]   k;

    logic [29:0]     waddr;
    logic [IDXB-1:0] idx;
    logic [TAGW-1:0] tag;
    logic [DW-1:0]   rd_ix;
    logic [DW-1:0]   wr_ix;
    logic            hit_raw;
    logic            miss_start;
    logic            fill_we;
    logic            fill_done;

    assign waddr = imemaddr[31:2];
    assign idx   = waddr[OFFB +: IDXB];
    assign tag   = waddr[29 -: TAGW];
    assign rd_ix = waddr[DW-1:0];

    // {fill_idx, k} with the word-offset field dropped when blocks are one word
    assign wr_ix = DW'({fill_idx, k} >> (KW - OFFB));

    assign hit_raw    = valid[idx] && (tags[idx] == tag);
    assign ihit       = (state == IDLE) && imemREN && !flush && hit_raw;
    assign imemload   = data[rd_ix];
    assign miss_start = (state == IDLE) && imemREN && !hit_raw && !flush;

    // Memory side depends only on registered fill state, never on imemaddr
    assign iREN      = (state == FILL);
    assign iaddr     = {fill_tag, wr_ix, 2'b00};
    assign fill_we   = (state == FILL) && !iwait;
    assign fill_done = fill_we && (k == LAST_K) && !flush && !RST;

    always_ff @(posedge CLK) begin
        if (fill_we) begin
            data[wr_ix] <= iload;
        end
        if (fill_done) begin
            tags[fill_idx] <= fill_tag;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            valid      <= '0;
            k          <= '0;
            fill_tag   <= '0;
            fill_idx   <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (ihit && (hit_count != '1)) begin
                hit_count <= hit_count + 1'b1;
            end
            if (flush) begin
                valid <= '0;
                state <= IDLE;
                k     <= '0;
            end else if (state == IDLE) begin
                if (miss_start) begin
                    state      <= FILL;
                    fill_tag   <= tag;
                    fill_idx   <= idx;
                    k          <= '0;
                    valid[idx] <= 1'b0;
                    if (miss_count != '1) begin
                        miss_count <= miss_count + 1'b1;
                    end
                end
            end else begin
                if (!iwait) begin
                    if (k == LAST_K) begin
                        valid[fill_idx] <= 1'b1;
                        state           <= IDLE;
                        k               <= '0;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
            end
        end
    end

endmodule
